lane_seq_mux: RTL
=================

# lane_seq_mux

Registered, parametrised N:1 lane multiplexer with an auto-sequencing mode, used in the optimised AES datapath. It captures a LANES×WIDTH word and either emits one selected lane or streams every lane in turn to a shared downstream unit, such as a single shared S-box. Input and output both use valid/ready handshakes.

## Interface
- WIDTH, 8: bits per lane.
- LANES, 4: number of lanes, ≥2; SEL_W = $clog2(LANES) is a derived localparam.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  LANES*WIDTH  lanes packed; lane 0 is in bits [WIDTH-1:0].
- in_mode  in  1  0 = DIRECT (one beat), 1 = SEQ (LANES beats); sampled at accept.
- in_sel  in  SEL_W  lane for DIRECT; sampled at accept.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  WIDTH  selected lane data.
- out_lane  out  SEL_W  index of lane in out_data.
- out_last  out  1  final beat of the current word.

## Operation
- States: IDLE, DIRECT, SEQ.
- Accept occurs when in_valid && in_ready.
  - On accept, in_data, in_mode and in_sel are registered.
  - The state becomes DIRECT or SEQ.
- in_ready is 1 in IDLE.
  - It is also 1 when the last beat completes in the same cycle (out_valid && out_ready && out_last). This allows back-to-back words with no bubble; in_ready depends combinationally on out_ready.
- DIRECT behaviour:
  - Emits one beat: out_lane = captured sel, out_last = 1.
  - On handshake, goes to IDLE, or reloads if a new word is accepted in the same cycle.
- SEQ behaviour:
  - Beat k carries lane (start+k) mod LANES, for k = 0..LANES-1. start = 0 unless the rotate feature is compiled in.
  - out_last = 1 on beat LANES-1 only.
  - The lane counter advances only on out_valid && out_ready.
  - After the last beat, goes to IDLE or reloads.
- Lane index wrap-around is modulo LANES, including for non-power-of-two LANES.
- In DIRECT, a captured sel ≥ LANES gives out_data = 0, out_lane = sel and out_last = 1. The beat still completes normally.
- While out_valid && !out_ready, out_data, out_lane and out_last hold stable.
- Reset mid-word: the word is discarded immediately and the block returns to IDLE.

## Timing
- Reset values, held while rst = 1:
  - out_valid = 0, out_data = 0, out_lane = 0, out_last = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after release.
- Latency: a word accepted at edge N gives its first beat valid after edge N (cycle N+1).
- Throughput:
  - DIRECT: one word per cycle with out_ready tied high.
  - SEQ: one word per LANES cycles with no idle gap.
- Each beat completes in exactly one out_valid && out_ready cycle. No beat is repeated or dropped.

## Configuration
- LANE_SEQ_ROTATE_EN, when defined:
  - Adds port in_rot (in, SEL_W), sampled at accept.
  - SEQ starts at lane in_rot mod LANES and wraps. This supports ShiftRows-ordered streaming.
  - DIRECT ignores in_rot.
- When undefined: the port is absent and SEQ always starts at lane 0.

## Structure
- Package lane_seq_pkg contains:
  - The state enum typedef (IDLE, DIRECT, SEQ).
  - Constants MODE_DIRECT = 1'b0 and MODE_SEQ = 1'b1.
- Sub-module lane_mux: a purely combinational WIDTH-bit, LANES:1 mux.
  - Output is zero for out-of-range selects.
  - One instance feeds the output register.
- Top level contains the capture register, the FSM, the lane counter and the output register.

## Test plan
All scenarios use WIDTH = 8 and LANES = 4.
- Reset then DIRECT: in_data = 32'hDDCCBBAA, mode 0, sel 2, out_ready = 1 → next cycle out_data = 8'hCC, out_lane = 2, out_last = 1, then IDLE.
- SEQ with out_ready = 1: in_data = 32'hDDCCBBAA → AA, BB, CC, DD on consecutive cycles, lanes 0..3, out_last only on DD. A second word offered at the DD cycle is accepted with no gap.
- Backpressure: SEQ with out_ready toggling 1,0,0,1,… → each beat is held stable while stalled and the sequence AA, BB, CC, DD is unchanged.
- Reset mid-SEQ after beat BB: out_valid = 0 immediately. After release, a new word streams from lane 0.
- With LANE_SEQ_ROTATE_EN, in_rot = 3, in_data = 32'hDDCCBBAA → DD, AA, BB, CC with lanes 3, 0, 1, 2, and out_last on CC.
- With LANES = 3 and DIRECT sel = 3 → out_data = 0, out_lane = 3, out_last = 1.

Source files
------------

// File: rtl/lane_seq_pkg.sv
// lane_seq_pkg: shared types and constants for the lane_seq_mux block.
package lane_seq_pkg;

  // Sequencer states: idle, single-beat word, LANES-beat streamed word.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SEQ    = 2'd2
  } state_t;

  // in_mode encodings, sampled when a word is accepted.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/lane_seq_mux_mux.sv
// lane_mux: combinational LANES:1 mux of WIDTH-bit lanes.
// Each lane is gated by its own select decode and the gated lanes are OR-ed,
// so a select that matches no lane (sel >= LANES) yields zero.
module lane_mux #(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic [LANES-1:0][WIDTH-1:0] data,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            y
);

  logic [LANES-1:0][WIDTH-1:0] gated;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign gated[i] = (sel == SEL_W'(i)) ? data[i] : '0;
  end

  // OR-reduce the gated lanes; at most one is non-zero.
  always_comb begin
    y = '0;
    for (int i = 0; i < LANES; i++) y = y | gated[i];
  end

endmodule

// File: rtl/lane_seq_mux.sv
// lane_seq_mux: registered LANES:1 lane mux with an auto-sequencing mode.
// A captured word is emitted either as one selected lane (DIRECT) or as all
// LANES lanes in turn (SEQ). Valid/ready on both sides.
// Optional feature macro LANE_SEQ_ROTATE_EN: adds in_rot, the SEQ start lane.
module lane_seq_mux
  import lane_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_mode,
  input  logic [SEL_W-1:0]       in_sel,
`ifdef LANE_SEQ_ROTATE_EN
  input  logic [SEL_W-1:0]       in_rot,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_lane,
  output logic                   out_last
);

  state_t                 state, state_nxt;
  logic [LANES*WIDTH-1:0] cap_data;   // captured word, source for later SEQ beats
  logic [SEL_W-1:0]       cnt;        // beat index within a SEQ word
  logic                   accept, done, adv;
  logic [SEL_W-1:0]       start_lane, first_lane, next_lane;
  logic [SEL_W:0]         lane_inc;
  logic [LANES*WIDTH-1:0] mux_src;
  logic [SEL_W-1:0]       mux_sel;
  logic [WIDTH-1:0]       mux_y;

  // Handshake terms. The last beat completing frees the block in the same
  // cycle, so in_ready looks through out_ready to allow back-to-back words.
  assign done     = out_valid && out_ready && out_last;
  assign adv      = out_valid && out_ready && !out_last;
  assign in_ready = !rst && ((state == IDLE) || done);
  assign accept   = in_valid && in_ready;

`ifdef LANE_SEQ_ROTATE_EN
  // in_rot spans fewer than 2*LANES values, so one conditional subtract
  // reduces it modulo LANES.
  assign start_lane = ({1'b0, in_rot} >= (SEL_W+1)'(LANES))
                    ? SEL_W'({1'b0, in_rot} - (SEL_W+1)'(LANES))
                    : in_rot;
`else
  assign start_lane = '0;
`endif

  // First beat lane of an incoming word; next lane of the running SEQ word
  // wraps at LANES (not at 2**SEL_W).
  assign first_lane = (in_mode == MODE_SEQ) ? start_lane : in_sel;
  assign lane_inc   = {1'b0, out_lane} + (SEL_W+1)'(1);
  assign next_lane  = (lane_inc >= (SEL_W+1)'(LANES)) ? '0 : lane_inc[SEL_W-1:0];

  // The single mux reads straight from in_data on accept so the first beat
  // is registered at the accepting edge; otherwise it reads the capture reg.
  assign mux_src = accept ? in_data : cap_data;
  assign mux_sel = accept ? first_lane : next_lane;

  lane_mux #(.WIDTH(WIDTH), .LANES(LANES)) u_mux (
    .data (mux_src),
    .sel  (mux_sel),
    .y    (mux_y)
  );

  // State register; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a new word reloads (possibly on the final beat), the final
  // beat with no new word returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (accept)    state_nxt = (in_mode == MODE_SEQ) ? SEQ : DIRECT;
    else if (done) state_nxt = IDLE;
  end

  // Capture register, beat counter and output register. The selected lane
  // of a DIRECT word lives in out_lane, and the mode in the state, so only
  // the data word needs a separate capture. Outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= (state_nxt != IDLE);
      if (accept) begin
        cap_data <= in_data;
        cnt      <= '0;
        out_data <= mux_y;
        out_lane <= first_lane;
        out_last <= (in_mode == MODE_DIRECT);
      end else if (adv) begin
        cnt      <= cnt + SEL_W'(1);
        out_data <= mux_y;
        out_lane <= next_lane;
        out_last <= (cnt == SEL_W'(LANES-2));
      end
    end
  end

endmodule
